// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer for slot 1: decodes load/store ops into an
// SRAM-like req/addr_ok/data_ok transaction, stalls until data returns, drains on flush.
module mem_access_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid_i,
  input  logic [7:0]        aluop1_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [DATA_W-1:0] reg2_i,
  input  logic              flush_i,
  input  logic              stall_i,
  output logic              stall_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  output logic [3:0]        data_wstrb,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

  state_t            state, state_next;
  logic              discard;
  logic              discard_eff;
  logic              capture;
  logic              stall_c;
  logic [1:0]        a;
  logic              is_mem, is_store, misal, fault, req_qual;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_wstrb;

  assign a = mem_addr_i[1:0];

  always_comb begin
    is_mem    = '0;
    is_store  = '0;
    misal     = '0;
    req_size  = 2'd2;
    req_addr  = mem_addr_i;
    req_wdata = '0;
    req_wstrb = '0;
    case (aluop1_i)
      EXE_LB_OP, EXE_LBU_OP: begin is_mem = '1; req_size = 2'd0; end
      EXE_LH_OP, EXE_LHU_OP: begin is_mem = '1; req_size = 2'd1; misal = a[0]; end
      EXE_LW_OP, EXE_LL_OP:  begin is_mem = '1; misal = |a; end
      EXE_LWL_OP, EXE_LWR_OP: begin
        is_mem   = '1;
        req_addr = {mem_addr_i[ADDR_W-1:2], 2'b00};
      end
      EXE_SB_OP: begin
        is_mem = '1; is_store = '1; req_size = 2'd0;
        req_wdata = {4{reg2_i[7:0]}};
        req_wstrb = 4'b0001 << a;
      end
      EXE_SH_OP: begin
        is_mem = '1; is_store = '1; req_size = 2'd1; misal = a[0];
        req_wdata = {2{reg2_i[15:0]}};
        req_wstrb = a[1] ? 4'b1100 : 4'b0011;
      end
      EXE_SW_OP, EXE_SC_OP: begin
        is_mem = '1; is_store = '1; misal = |a;
        req_wdata = reg2_i;
        req_wstrb = '1;
      end
      // Unaligned partial stores: shift amount 8*(3-a) is {~a, 3'b000}
      EXE_SWL_OP: begin
        is_mem = '1; is_store = '1;
        req_addr  = {mem_addr_i[ADDR_W-1:2], 2'b00};
        req_wdata = reg2_i >> {~a, 3'b000};
        req_wstrb = 4'b1111 >> ~a;
      end
      EXE_SWR_OP: begin
        is_mem = '1; is_store = '1;
        req_addr  = {mem_addr_i[ADDR_W-1:2], 2'b00};
        req_wdata = reg2_i << {a, 3'b000};
        req_wstrb = 4'b1111 << a;
      end
      default: ;
    endcase
  end

  assign fault    = mem_valid_i & is_mem & misal;
  assign req_qual = mem_valid_i & is_mem & ~misal & ~flush_i;
  assign adel_o   = rst & fault & ~is_store;
  assign ades_o   = rst & fault & is_store;
  assign data_req = (state == ADDR);
  assign stall_o  = rst & stall_c;

  // A flush arriving this cycle already counts as discarding, so a same-cycle data_ok is dropped
  assign discard_eff = discard | flush_i;

  always_comb begin
    state_next = state;
    stall_c    = '0;
    capture    = '0;
    case (state)
      IDLE: begin
        stall_c = req_qual;
        if (req_qual) state_next = ADDR;
      end
      ADDR: begin
        stall_c = discard_eff ? req_qual : 1'b1;
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_next = discard_eff ? IDLE : DONE;
            capture    = ~discard_eff;
          end else begin
            state_next = DATA;
          end
        end
      end
      DATA: begin
        stall_c = discard_eff ? req_qual : 1'b1;
        if (data_data_ok) begin
          state_next = discard_eff ? IDLE : DONE;
          capture    = ~discard_eff;
        end
      end
      DONE: begin
        if (!stall_i || flush_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      discard <= '0;
    end else begin
      state   <= state_next;
      discard <= (state_next != IDLE) &
                 (discard | (((state == ADDR) | (state == DATA)) & flush_i));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_wr    <= '0;
      data_size  <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      mem_data_o <= '0;
    end else begin
      if (state == IDLE && req_qual) begin
        data_wr    <= is_store;
        data_size  <= req_size;
        data_addr  <= req_addr;
        data_wdata <= req_wdata;
        data_wstrb <= req_wstrb;
      end
      if (capture && !data_wr) mem_data_o <= data_rdata;
    end
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-memory accesses for the MEM stage of the dual-issue pipeline. Only slot 1 carries memory ops.
Translates the slot-1 load/store op and address into an SRAM-like request/handshake transaction: word address, size, byte strobes and lane-aligned write data.
Stalls the pipeline until the data phase completes, then holds the raw read word for MEM-stage load extraction/merge.
Detects misaligned accesses and handles exception flush, including draining an in-flight transaction.

Parameters:
ADDR_W, 32, data bus address width
DATA_W, 32, data bus width (fixed at 32; byte-lane logic assumes 4 lanes)

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-low
mem_valid_i  input  1  slot-1 instruction in MEM is valid and not yet completed
aluop1_i  input  AluOpBus  slot-1 op; EXE_* encodings from the shared defines header
mem_addr_i  input  32  effective byte address
reg2_i  input  32  store source register
flush_i  input  1  exception/ERET flush of MEM and younger stages
stall_i  input  1  stall from another source holding MEM
stall_o  output  1  MEM must hold (access outstanding)
mem_data_o  output  32  raw read word, valid when the state is DONE
adel_o  output  1  load address error
ades_o  output  1  store address error
data_req  output  1  bus request
data_wr  output  1  1 = write
data_size  output  2  0 = byte, 1 = half, 2 = word
data_addr  output  32  bus address
data_wdata  output  32  lane-aligned write data
data_wstrb  output  4  byte write strobes
data_addr_ok  input  1  address phase accepted
data_data_ok  input  1  data phase complete
data_rdata  input  32  read data

Behaviour:
- Mem ops: LB, LBU, LH, LHU, LW, LWL, LWR, LL, SB, SH, SW, SWL, SWR, SC. All other ops are not mem ops, and the block is transparent for them: stall_o = 0, no req.
- Alignment, combinational:
  - LH/LHU with addr[0] = 1 → adel_o.
  - LW/LL with addr[1:0] ≠ 0 → adel_o.
  - SH with addr[0] = 1, or SW/SC with addr[1:0] ≠ 0 → ades_o.
  - A faulting op issues no request and does not stall.
- Bus address/size:
  - LWL/LWR/SWL/SWR: data_addr = {addr[31:2], 2'b00}, size = 2.
  - Byte ops: size = 0. Half ops: size = 1. Word ops: size = 2. Full address otherwise.
- Write data and strobes, by a = addr[1:0]:
  - SB: wdata = {4{reg2[7:0]}}, wstrb = 1 << a.
  - SH: wdata = {2{reg2[15:0]}}, wstrb = 0011 (a = 0) or 1100 (a = 2).
  - SW/SC: wdata = reg2, wstrb = 1111.
  - SWL: a = 0 → {24'b0, reg2[31:24]}, 0001; a = 1 → {16'b0, reg2[31:16]}, 0011; a = 2 → {8'b0, reg2[31:8]}, 0111; a = 3 → reg2, 1111.
  - SWR: a = 0 → reg2, 1111; a = 1 → {reg2[23:0], 8'b0}, 1110; a = 2 → {reg2[15:0], 16'b0}, 1100; a = 3 → {reg2[7:0], 24'b0}, 1000.
  - Loads: wstrb = 0000.
- FSM states: IDLE, ADDR, DATA, DONE.
  - IDLE: on (mem_valid_i & mem op & no fault & !flush_i), go to ADDR. Address, size, wdata, wstrb and wr are registered and held stable for the whole transaction.
  - ADDR: data_req = 1. On data_addr_ok, go to DATA. Req holds until addr_ok, even when flushed.
  - DATA: on data_data_ok, capture data_rdata into mem_data_o (loads only) and go to DONE. If the discard flag is set, go to IDLE instead.
  - DONE: stall_o = 0. Stay while stall_i = 1. Go to IDLE when stall_i = 0 or flush_i = 1.
  - data_addr_ok and data_data_ok in the same cycle while in ADDR: go directly to DONE, capturing rdata.
- stall_o:
  - stall_o = 1 combinationally in IDLE when a qualifying request is present.
  - stall_o = 1 in ADDR and DATA, unless the discard flag is set.
  - While discarding, a new valid mem request sees stall_o = 1 until the FSM returns to IDLE.
- Flush: flush_i in ADDR or DATA sets the discard flag. The transaction completes on the bus, its data is dropped, and the flag clears on return to IDLE.
- Reset (async, rst = 0):
  - State = IDLE, discard = 0.
  - All outputs 0: data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb, mem_data_o, stall_o, adel_o, ades_o.
  - Reset mid-transaction abandons it.
- Minimum load latency: request seen in IDLE at cycle 0 → req in cycle 1; data returned at earliest end of cycle 1 (addr_ok and data_ok together) → DONE in cycle 2.

Test Plan:
- LW addr 0x1000, addr_ok after 2 cycles, data_ok 1 cycle later with rdata 0xDEADBEEF → req held 2 cycles, addr 0x1000, size 2, stall_o high until DONE, mem_data_o = 0xDEADBEEF.
- SB reg2 = 0x12345678 to addr 0x2003 → wdata 0x78787878, wstrb 1000, size 0, wr 1.
- SWL addr 0x3001, reg2 = 0xAABBCCDD → data_addr 0x3000, wdata 0x0000AABB, wstrb 0011; SWR addr 0x3002 → wdata 0xCCDD0000, wstrb 1100.
- LH addr 0x4001 → adel_o = 1, data_req never asserted, stall_o = 0; SW addr 0x4002 → ades_o = 1.
- flush_i in DATA, data_ok 2 cycles later → stall_o drops immediately; FSM returns to IDLE; mem_data_o unchanged; next LW is accepted only after the drain completes.
- rst low while in ADDR → all outputs 0 asynchronously; after release, state is IDLE with no req.
